subneg_fetch: RTL and testbench
===============================

Name: subneg_fetch

Overview:
- Program-counter and operand-fetch sequencer for the SUBNEG core.
- Holds the PC and reads the three words of each instruction (A, B, C) from memory over a request/valid handshake.
- Sits directly upstream of the `inc` incrementer: drives `inc`'s input with the PC and takes `inc`'s output as the next sequential PC.
- Hands a complete instruction to the execute stage over a valid/ready handshake and takes a branch decision back.

Parameters:
- WIDTH, 8, data/address width; PC and operands are signed WIDTH bits.
- START_ADDR, 0, PC value after reset and after each `start` from IDLE/HALTED.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; begins fetching at START_ADDR when in IDLE or HALTED.
- mem_rd, output, 1, memory read request, one-cycle pulse.
- mem_addr, output, WIDTH, read address (raw PC bits).
- mem_rdata, input, WIDTH, read data; valid when mem_valid=1.
- mem_valid, input, 1, read data strobe; arrives 1+ cycles after mem_rd.
- inc_in, output, WIDTH, current PC, fed to `inc`.
- inc_out, input, WIDTH, PC+1 from `inc` (signed wrap).
- op_a, output, WIDTH, fetched operand A.
- op_b, output, WIDTH, fetched operand B.
- op_c, output, WIDTH, fetched operand C (branch target).
- instr_valid, output, 1, op_a/op_b/op_c hold a complete instruction.
- instr_ready, input, 1, execute stage accepts the instruction.
- branch_taken, input, 1, sampled with the instr_valid & instr_ready handshake; 1 means result was negative, so branch to op_c.
- pc, output, WIDTH, current PC.
- busy, output, 1, high in every state except IDLE and HALTED.
- halted, output, 1, high in HALTED.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, pc=START_ADDR, operand index=0.
  - op_a, op_b, op_c = 0; mem_rd, instr_valid, busy, halted = 0.
  - Reset during any state aborts immediately. An outstanding mem_valid after reset release is ignored.
- inc_in = pc at all times, combinationally. mem_addr = pc.
- IDLE: on start, go to REQ with pc=START_ADDR and index=0. Otherwise stay.
- REQ:
  - mem_rd=1 for exactly one cycle, then go to WAIT.
- WAIT:
  - Hold mem_rd=0. mem_valid is ignored in every state other than WAIT.
  - On mem_valid: write mem_rdata into op[index] (0=A, 1=B, 2=C), load pc <= inc_out, then:
    - index < 2: index++, go to REQ.
    - index == 2: go to ISSUE.
- ISSUE:
  - instr_valid=1, operands stable until the handshake.
  - On instr_valid & instr_ready:
    - branch_taken=0: pc unchanged (already PC+3 of the instruction), index=0, go to REQ.
    - branch_taken=1 and op_c MSB=0: pc <= op_c, index=0, go to REQ.
    - branch_taken=1 and op_c MSB=1 (negative target): halt. Go to HALTED, pc unchanged.
  - instr_valid drops in the cycle after the handshake.
- HALTED: halted=1. On start, go to REQ with pc=START_ADDR.
- Ignored inputs:
  - start while busy is ignored.
  - instr_ready outside ISSUE is ignored.
- Arithmetic:
  - The PC advances only through inc_out.
  - Wrap 0x7F to 0x80 (WIDTH=8) is legal and does not halt; only a taken negative branch halts.
- Minimum latency, zero-wait memory (mem_valid the cycle after mem_rd): 6 cycles from the first mem_rd to instr_valid.

Optional Feature:
- Macro: SUBNEG_FETCH_CNT_EN.
- Defined:
  - Adds output instr_count, 16 bits.
  - Resets to 0 and is cleared on start.
  - Increments by 1 on each ISSUE handshake, saturating at 0xFFFF.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start, memory[0..2]={5,6,9}, 1-cycle memory, instr_ready=1, branch_taken=0:
  - op_a=5, op_b=6, op_c=9, instr_valid for 1 cycle.
  - Next mem_addr=3; inc_in tracks 0,1,2,3.
- Taken branch: memory[0..2]={1,2,0x10}, branch_taken=1 → next mem_addr=0x10, pc=0x10.
- Halt: op_c=0xF0 with branch_taken=1:
  - halted=1, busy=0, no further mem_rd.
  - A later start restarts at START_ADDR.
- Backpressure and slow memory:
  - mem_valid delayed 3 cycles per read, instr_ready low for 4 cycles.
  - Operands stay stable, a single mem_rd per word, no PC advance during the stall.
- Wrap: START_ADDR=0x7E, sequential fetch → addresses 0x7E, 0x7F, 0x80, no halt.
- Asynchronous reset asserted in WAIT with mem_valid pending:
  - Outputs return to reset values immediately.
  - A stray mem_valid after release does not change the operands.
  - With SUBNEG_FETCH_CNT_EN defined, instr_count=0 after reset and counts 3 after three handshakes.

Source files
------------

// File: rtl/subneg_fetch.sv
// subneg_fetch -- PC and operand-fetch sequencer for the SUBNEG core.
//
// Holds the program counter, reads the three words of each instruction
// (A, B, C) over a request/valid memory handshake, and hands the complete
// instruction to the execute stage. The PC only ever advances through the
// external `inc` incrementer (inc_in -> inc_out), or jumps to op_c on a
// taken branch. A taken branch to a negative target halts the sequencer.
//
// Handshakes:
//   memory : mem_rd is a one-cycle request for the word at mem_addr; the
//            reply is the single cycle in which mem_valid=1 (1+ cycles
//            later). mem_valid is only honoured while waiting for a reply.
//   execute: the instruction transfers on a rising clock edge where
//            instr_valid=1 and instr_ready=1; branch_taken is sampled on
//            that same edge. op_a/op_b/op_c are stable while instr_valid=1.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                pulse; (re)starts fetching at START_ADDR from IDLE/HALTED
//   mem_rd, mem_addr     read request and address (mem_addr = pc)
//   mem_rdata, mem_valid read data and its strobe
//   inc_in, inc_out      pc to the incrementer, pc+1 back from it
//   op_a, op_b, op_c     fetched operands
//   instr_valid          operands hold a complete instruction
//   instr_ready          execute stage accepts it
//   branch_taken         1 = branch to op_c (sampled with the handshake)
//   pc, busy, halted     status
//   instr_count          handshake counter, only with SUBNEG_FETCH_CNT_EN defined
//   state_dbg            current FSM state (IDLE=0 REQ=1 WAIT=2 ISSUE=3 HALTED=4)
//
// Optional feature: define SUBNEG_FETCH_CNT_EN to add the saturating 16-bit
// instr_count output.

module subneg_fetch #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] START_ADDR = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             mem_rd,
  output logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_valid,
  output logic [WIDTH-1:0] inc_in,
  input  logic [WIDTH-1:0] inc_out,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] op_c,
  output logic             instr_valid,
  input  logic             instr_ready,
  input  logic             branch_taken,
  output logic [WIDTH-1:0] pc,
  output logic             busy,
  output logic             halted,
`ifdef SUBNEG_FETCH_CNT_EN
  output logic [15:0]      instr_count,
`endif
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_ISSUE  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t     state;
  logic [1:0] idx;        // operand being fetched: 0=A, 1=B, 2=C
  logic       start_acc;  // start seen while not busy
  logic       issue_hs;   // instruction accepted by execute this cycle

  assign inc_in    = pc;
  assign mem_addr  = pc;
  assign state_dbg = state;

  assign start_acc = start && (state == S_IDLE || state == S_HALTED);
  assign issue_hs  = (state == S_ISSUE) && instr_ready;

  // All status outputs are registered alongside the state so they change
  // exactly on the transitions that define them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= START_ADDR;
      idx         <= 2'd0;
      op_a        <= '0;
      op_b        <= '0;
      op_c        <= '0;
      mem_rd      <= 1'b0;
      instr_valid <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: begin
          if (start_acc) begin
            state  <= S_REQ;
            pc     <= START_ADDR;
            idx    <= 2'd0;
            mem_rd <= 1'b1;
            busy   <= 1'b1;
            halted <= 1'b0;
          end
        end
        S_REQ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_valid) begin
            case (idx)
              2'd0:    op_a <= mem_rdata;
              2'd1:    op_b <= mem_rdata;
              default: op_c <= mem_rdata;
            endcase
            pc <= inc_out;
            if (idx == 2'd2) begin
              state       <= S_ISSUE;
              instr_valid <= 1'b1;
            end else begin
              idx    <= idx + 2'd1;
              state  <= S_REQ;
              mem_rd <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (issue_hs) begin
            instr_valid <= 1'b0;
            idx         <= 2'd0;
            if (branch_taken && op_c[WIDTH-1]) begin
              // Taken branch to a negative target is the halt instruction.
              state  <= S_HALTED;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              if (branch_taken) pc <= op_c;
              state  <= S_REQ;
              mem_rd <= 1'b1;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          instr_valid <= 1'b0;
          busy        <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SUBNEG_FETCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= 16'd0;
    end else if (start_acc) begin
      instr_count <= 16'd0;
    end else if (issue_hs && instr_count != 16'hFFFF) begin
      instr_count <= instr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_subneg_fetch.sv
// tb_subneg_fetch -- self-checking bench for subneg_fetch (WIDTH=8, START_ADDR=0).
// Memory and the `inc` incrementer are modelled here; the expected program
// flow comes from a reference model of the instruction-set rules.

module tb_subneg_fetch;

  localparam int         W     = 8;
  localparam logic [7:0] START = 8'h00;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         mem_rd;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_rdata;
  logic         mem_valid;
  logic [W-1:0] inc_in;
  logic [W-1:0] inc_out;
  logic [W-1:0] op_a, op_b, op_c;
  logic         instr_valid;
  logic         instr_ready;
  logic         branch_taken;
  logic [W-1:0] pc;
  logic         busy;
  logic         halted;
  logic [2:0]   state_dbg;
`ifdef SUBNEG_FETCH_CNT_EN
  logic [15:0]  instr_count;
`endif

  subneg_fetch #(.WIDTH(W), .START_ADDR(START)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid),
    .inc_in       (inc_in),
    .inc_out      (inc_out),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_c         (op_c),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .pc           (pc),
    .busy         (busy),
    .halted       (halted),
`ifdef SUBNEG_FETCH_CNT_EN
    .instr_count  (instr_count),
`endif
    .state_dbg    (state_dbg)
  );

  // The incrementer that sits downstream of the fetch unit.
  assign inc_out = inc_in + 8'd1;

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc;
  initial begin
    cyc = 0;
    forever @(posedge clk) cyc++;
  end

  // ---------------- memory responder ----------------
  logic [7:0] mem [256];
  int         mem_lat;
  int         rsp_cnt;
  logic [7:0] rsp_addr;
  int         rd_n;
  logic [7:0] rd_log [$];
  int         rd_cyc [$];

  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    rsp_cnt   = 0;
    rsp_addr  = '0;
    rd_n      = 0;
    forever begin
      @(negedge clk);
      mem_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_valid = 1'b1;
          mem_rdata = mem[rsp_addr];
        end
      end
      if (mem_rd === 1'b1) begin
        rsp_addr = mem_addr;
        rsp_cnt  = mem_lat;
        rd_log.push_back(mem_addr);
        rd_cyc.push_back(cyc);
        rd_n++;
      end
    end
  end

  // ---------------- scoreboard / model state ----------------
  int           total;
  int           bad;
  int           rd_seen;
  int           last_iv_cyc;
  logic [7:0]   m_pc;
  bit           m_halted;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc     = START;
    m_halted = 1'b0;
  endtask

  // Fetch and retire one instruction at the model PC. Expected operands are
  // the memory words at pc, pc+1, pc+2 (8-bit wrap); the next PC follows the
  // SUBNEG branch rules.
  task automatic run_instr(input logic tk, input int dly);
    int         to;
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] ea, eb, ec;
    bit         will_halt;
    a0 = m_pc;
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    ea = mem[a0];
    eb = mem[a1];
    ec = mem[a2];
    exp_q.push_back(a0);
    exp_q.push_back(a1);
    exp_q.push_back(a2);
    to = 0;
    while (instr_valid !== 1'b1 && to < 200) begin
      @(negedge clk);
      to++;
    end
    last_iv_cyc = cyc;
    chk("instr_valid_timeout", {31'd0, instr_valid}, 32'd1);
    chk("op_a", op_a, ea);
    chk("op_b", op_b, eb);
    chk("op_c", op_c, ec);
    chk("pc_at_issue", pc, a3);
    chk("inc_in_at_issue", inc_in, a3);
    chk("reads_per_instr", rd_n - rd_seen, 3);
    if (rd_n - rd_seen == 3) begin
      for (int k = 0; k < 3; k++) chk("read_addr", rd_log[rd_seen + k], exp_q.pop_front());
    end
    exp_q.delete();
    rd_seen = rd_n;
    instr_ready = 1'b0;
    for (int s = 0; s < dly; s++) begin
      @(negedge clk);
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_op_a", op_a, ea);
      chk("stall_op_b", op_b, eb);
      chk("stall_op_c", op_c, ec);
      chk("stall_pc", pc, a3);
      chk("stall_no_read", rd_n, rd_seen);
    end
    instr_ready  = 1'b1;
    branch_taken = tk;
    @(negedge clk);
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    will_halt = tk && ec[7];
    if (tk && !ec[7]) m_pc = ec;
    else              m_pc = a3;
    m_halted = will_halt;
    chk("valid_drops", {31'd0, instr_valid}, 32'd0);
    chk("halted_after", {31'd0, halted}, {31'd0, will_halt});
    chk("busy_after", {31'd0, busy}, {31'd0, !will_halt});
    chk("pc_after", pc, m_pc);
    chk("mem_addr_after", mem_addr, m_pc);
    chk("mem_rd_after", {31'd0, mem_rd}, {31'd0, !will_halt});
  endtask

  task automatic check_halt_quiet();
    repeat (5) @(negedge clk);
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_busy", {31'd0, busy}, 32'd0);
    chk("halt_no_read", rd_n, rd_seen);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [7:0] addr;
    logic [7:0] a, b, c;
    logic       taken;
    logic [7:0] exp_pc;
    logic       exp_halt;
  } vec_t;

  vec_t tbl [6];

  initial begin
    total = 0; bad = 0; rd_seen = 0; last_iv_cyc = 0;
    mem_lat = 1; m_pc = START; m_halted = 1'b0;
    rst_n = 1'b0; start = 1'b0; instr_ready = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Chained program: each row is fetched from where the previous one left pc.
    tbl[0] = '{addr: 8'h00, a: 8'd5, b: 8'd6, c: 8'd9,    taken: 1'b0, exp_pc: 8'h03, exp_halt: 1'b0};
    tbl[1] = '{addr: 8'h03, a: 8'd1, b: 8'd2, c: 8'h10,   taken: 1'b1, exp_pc: 8'h10, exp_halt: 1'b0};
    tbl[2] = '{addr: 8'h10, a: 8'd7, b: 8'd7, c: 8'h20,   taken: 1'b0, exp_pc: 8'h13, exp_halt: 1'b0};
    tbl[3] = '{addr: 8'h13, a: 8'd3, b: 8'd4, c: 8'h7E,   taken: 1'b1, exp_pc: 8'h7E, exp_halt: 1'b0};
    tbl[4] = '{addr: 8'h7E, a: 8'd8, b: 8'd9, c: 8'h40,   taken: 1'b0, exp_pc: 8'h81, exp_halt: 1'b0};
    tbl[5] = '{addr: 8'h81, a: 8'd1, b: 8'd1, c: 8'hF0,   taken: 1'b1, exp_pc: 8'h84, exp_halt: 1'b1};
    for (int i = 0; i < 6; i++) begin
      mem[tbl[i].addr]        = tbl[i].a;
      mem[tbl[i].addr + 8'd1] = tbl[i].b;
      mem[tbl[i].addr + 8'd2] = tbl[i].c;
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_pc", pc, START);
    chk("rst_inc_in", inc_in, START);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_ops", {8'd0, op_a, op_b, op_c}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_no_read", rd_n, 0);

    // Table-driven program including wrap 0x7F->0x80 and the halting branch
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      run_instr(tbl[i].taken, 0);
      if (i == 0) chk("first_latency", last_iv_cyc - rd_cyc[0], 6);
      chk("tbl_pc", pc, tbl[i].exp_pc);
      chk("tbl_halted", {31'd0, halted}, {31'd0, tbl[i].exp_halt});
    end
    check_halt_quiet();
    start = 1'b1;  // start while halted restarts at START_ADDR
    @(negedge clk);
    start = 1'b0;
    m_pc = START; m_halted = 1'b0;
    chk("restart_addr", mem_addr, START);
    run_instr(1'b0, 0);

    // Start while busy is ignored; slow memory plus backpressure
    mem_lat = 3;
    start = 1'b1;
    run_instr(1'b0, 4);
    start = 1'b0;
    run_instr(1'b0, 2);

    // Asynchronous reset while waiting for a read reply
    mem_lat = 3;
    repeat (8) @(negedge clk);  // drain any in-flight reply before re-entry
    rd_seen = rd_n;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    chk("pre_rst_mem_rd", {31'd0, mem_rd}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("arst_pc", pc, START);
    chk("arst_ops", {8'd0, op_a, op_b, op_c}, 32'd0);
`ifdef SUBNEG_FETCH_CNT_EN
    chk("arst_count", {16'd0, instr_count}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    rd_seen = rd_n;
    repeat (5) @(negedge clk);  // stray mem_valid arrives in here
    chk("stray_ops", {8'd0, op_a, op_b, op_c}, 32'd0);
    chk("stray_busy", {31'd0, busy}, 32'd0);
    chk("stray_pc", pc, START);
    chk("stray_no_read", rd_n, rd_seen);
    mem_lat = 1;
    pulse_start();
    for (int i = 0; i < 3; i++) run_instr(1'b0, 0);
`ifdef SUBNEG_FETCH_CNT_EN
    chk("count_three", {16'd0, instr_count}, 32'd3);
`endif

    // Randomized program against the reference model
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 40; n++) begin
      mem_lat = $urandom_range(1, 3);
      run_instr(1'($urandom_range(0, 1)), $urandom_range(0, 3));
      if (m_halted) begin
        check_halt_quiet();
        pulse_start();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
